// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// mux selects, ALU operations and the per-state control word.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    aluop_t     alu_op;
    logic       branch;
    logic       pc_update;
  } ctrl_t;

  // Moore control word for a state; anything not set stays at zero / add.
  function automatic ctrl_t state_ctrl(input state_t st);
    ctrl_t c;
    c            = '0;
    c.alu_op     = ALUOP_ADD;
    case (st)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
        c.mem_write  = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      default: begin
        c.alu_op = ALUOP_ADD;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction funct fields to an ALU operation.
module alu_decoder
  import riscv_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // sub only for R-type with funct7b5 set; I-type addi ignores instr[30]
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (op5 && funct7b5) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM. The control word is registered alongside
// the state, so every Moore output is a clean flop output.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Next-state selection; unsupported opcodes fall back to FETCH from DECODE
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
    ctrl_d = state_ctrl(state_d);
  end

  // State and control-word register; reset parks both on FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LW, OP_ITYPE: ImmSrc = IMM_I;
      OP_SW:           ImmSrc = IMM_S;
      OP_BEQ:          ImmSrc = IMM_B;
      OP_JAL:          ImmSrc = IMM_J;
      default:         ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

  assign PCWrite   = ctrl_q.pc_update | (ctrl_q.branch & Zero);
  assign AdrSrc    = ctrl_q.adr_src;
  assign MemWrite  = ctrl_q.mem_write;
  assign IRWrite   = ctrl_q.ir_write;
  assign RegWrite  = ctrl_q.reg_write;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each instruction pushes one
// expected output vector per cycle; a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  localparam int ST_F   = 0;
  localparam int ST_D   = 1;
  localparam int ST_MA  = 2;
  localparam int ST_MR  = 3;
  localparam int ST_MWB = 4;
  localparam int ST_MW  = 5;
  localparam int ST_XR  = 6;
  localparam int ST_XI  = 7;
  localparam int ST_AWB = 8;
  localparam int ST_BEQ = 9;
  localparam int ST_JAL = 10;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  // Expected outputs per state, vector {PCW,Adr,MemW,IRW,RegW,RS,SA,SB,Imm,ALUC}
  function automatic logic [15:0] exp_vec(input int st, input logic z,
                                          input logic [1:0] imm, input logic [2:0] fc);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] ac;
    pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; ac = 3'b000;
    case (st)
      ST_F:   begin pcw = 1'b1; irw = 1'b1; rs = 2'b10; sb = 2'b10; end
      ST_D:   begin sa = 2'b01; sb = 2'b01; end
      ST_MA:  begin sa = 2'b10; sb = 2'b01; end
      ST_MR:  begin adr = 1'b1; end
      ST_MW:  begin adr = 1'b1; mw = 1'b1; end
      ST_MWB: begin rs = 2'b01; rw = 1'b1; end
      ST_XR:  begin sa = 2'b10; sb = 2'b00; ac = fc; end
      ST_XI:  begin sa = 2'b10; sb = 2'b01; ac = fc; end
      ST_AWB: begin rw = 1'b1; end
      ST_BEQ: begin sa = 2'b10; ac = 3'b001; pcw = z; end
      ST_JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      default: begin pcw = 1'b0; end
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, ac};
  endfunction

  function automatic string st_name(input int st);
    case (st)
      ST_F: return "FETCH";     ST_D: return "DECODE";
      ST_MA: return "MEMADR";   ST_MR: return "MEMREAD";
      ST_MWB: return "MEMWB";   ST_MW: return "MEMWRITE";
      ST_XR: return "EXECUTER"; ST_XI: return "EXECUTEI";
      ST_AWB: return "ALUWB";   ST_BEQ: return "BEQ";
      ST_JAL: return "JAL";     default: return "?";
    endcase
  endfunction

  task automatic push_exp(input int st, input logic z, input logic [1:0] imm,
                          input logic [2:0] fc, input string name, input int cyc);
    exp_q.push_back(exp_vec(st, z, imm, fc));
    tag_q.push_back($sformatf("%s_c%0d_%s", name, cyc, st_name(st)));
  endtask

  // Drive one instruction from FETCH, queue its per-cycle expectations, wait it out
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic [1:0] imm, input logic [2:0] fc,
                           input string name);
    int seq[5];
    int n;
    seq = '{ST_F, ST_D, ST_F, ST_F, ST_F};
    n = 2;
    case (o)
      7'b0000011: begin seq = '{ST_F, ST_D, ST_MA, ST_MR, ST_MWB}; n = 5; end
      7'b0100011: begin seq = '{ST_F, ST_D, ST_MA, ST_MW, ST_F};   n = 4; end
      7'b0110011: begin seq = '{ST_F, ST_D, ST_XR, ST_AWB, ST_F};  n = 4; end
      7'b0010011: begin seq = '{ST_F, ST_D, ST_XI, ST_AWB, ST_F};  n = 4; end
      7'b1100011: begin seq = '{ST_F, ST_D, ST_BEQ, ST_F, ST_F};   n = 3; end
      7'b1101111: begin seq = '{ST_F, ST_D, ST_JAL, ST_AWB, ST_F}; n = 4; end
      default:    begin seq = '{ST_F, ST_D, ST_F, ST_F, ST_F};     n = 2; end
    endcase
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    for (int i = 0; i < n; i++) push_exp(seq[i], z, imm, fc, name, i + 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: one output vector per cycle, checked on the falling edge
  always @(negedge clk) begin
    logic [15:0] e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s actual=%b required=%b", t, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    push_exp(ST_F, 1'b0, 2'b00, 3'b000, "reset", 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000, "lw");
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 3'b000, "sw");
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b001, "r_sub");
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, "r_add");
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b000, "addi_f7");
    run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b101, "r_slt");
    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 2'b00, 3'b011, "r_or");
    run_instr(7'b0010011, 3'b111, 1'b0, 1'b0, 2'b00, 3'b010, "andi");
    run_instr(7'b0110011, 3'b100, 1'b0, 1'b0, 2'b00, 3'b000, "r_xor_dflt");
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, 3'b000, "beq_taken");
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10, 3'b000, "beq_not");
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 2'b11, 3'b000, "jal");
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, "bad_op");

    // lw interrupted by reset while in MEMREAD
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    push_exp(ST_F,  1'b0, 2'b00, 3'b000, "lw_abort", 1);
    push_exp(ST_D,  1'b0, 2'b00, 3'b000, "lw_abort", 2);
    push_exp(ST_MA, 1'b0, 2'b00, 3'b000, "lw_abort", 3);
    push_exp(ST_MR, 1'b0, 2'b00, 3'b000, "lw_abort", 4);
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    push_exp(ST_F, 1'b0, 2'b00, 3'b000, "in_reset", 1);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000, "lw_after_rst");
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b001, "r_sub2");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
